// File: rtl/riscv_mem_pkg.sv
// Shared memory-path definitions: access size codes, arbiter states and
// requester IDs used by the RAM port arbiter and its read-return tag pipe.
package riscv_mem_pkg;

  typedef enum logic [2:0] {
    RW_B  = 3'b000,
    RW_H  = 3'b001,
    RW_W  = 3'b010,
    RW_BU = 3'b100,
    RW_HU = 3'b101
  } rw_type_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN0  = 2'd1,
    ARB_OWN1  = 2'd2,
    ARB_GUARD = 2'd3
  } arb_state_e;

  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep valid+ID shift register. A tag enters on every RAM read issue
// and pops out exactly when the RAM returns that read's data.
module rd_tag_pipe
  import riscv_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vld,
  input  logic i_id,
  output logic o_vld,
  output logic o_id
);

  logic [RD_LAT:1] r_vld_pipe;
  logic [RD_LAT:1] r_id_pipe;
  logic [RD_LAT:1] w_vld_nxt;
  logic [RD_LAT:1] w_id_nxt;

  if (RD_LAT == 1) begin : g_one
    assign w_vld_nxt = i_vld;
    assign w_id_nxt  = i_id;
  end else begin : g_many
    assign w_vld_nxt = {r_vld_pipe[RD_LAT-1:1], i_vld};
    assign w_id_nxt  = {r_id_pipe[RD_LAT-1:1], i_id};
  end

  // Shift tags one stage per cycle; reset drops anything still in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
    end else begin
      r_vld_pipe <= w_vld_nxt;
      r_id_pipe  <= w_id_nxt;
    end
  end

  assign o_vld = r_vld_pipe[RD_LAT];
  assign o_id  = r_id_pipe[RD_LAT];

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for the single data-RAM port. M0 is the core load/store
// path, M1 the loader/debug master. Round-robin when both ask, M1 may lock
// the port for bursts, and a guard slot lets a waiting M0 in every
// MAX_BURST locked M1 beats. Grants are combinational from registered state.
module ram_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_m0_req,
  input  logic          i_m0_wr,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [2:0]    i_m0_type,
  input  logic [DW-1:0] i_m0_wdata,
  output logic          o_m0_gnt,
  output logic          o_m0_rvalid,
  output logic [DW-1:0] o_m0_rdata,
  input  logic          i_m1_req,
  input  logic          i_m1_wr,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [2:0]    i_m1_type,
  input  logic [DW-1:0] i_m1_wdata,
  input  logic          i_m1_lock,
  output logic          o_m1_gnt,
  output logic          o_m1_rvalid,
  output logic [DW-1:0] o_m1_rdata,
  output logic          o_ram_rd_en,
  output logic          o_ram_wr_en,
  output logic [AW-1:0] o_ram_addr,
  output logic [2:0]    o_ram_type,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic          r_last;
  logic          w_last_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_rr_g0;
  logic          w_rr_g1;
  logic          w_g0;
  logic          w_g1;
  logic          w_wr;
  logic          w_tag_vld;
  logic          w_tag_id;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;

  // Fair pick: the master that did not win last time gets the tie.
  assign w_rr_g0 = i_m0_req & (~i_m1_req | (r_last == MST_M1));
  assign w_rr_g1 = i_m1_req & ~w_rr_g0;

  // Grant decode. A locked owner only keeps the port while it is actually
  // requesting; otherwise the cycle falls back to the fair pick, so a bare
  // lock never stalls M0. Grants are held off while reset is asserted.
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    case (r_state)
      ARB_GUARD: begin
        if (i_m0_req) begin
          w_g0 = 1'b1;
        end else begin
          w_g0 = w_rr_g0;
          w_g1 = w_rr_g1;
        end
      end
      ARB_OWN1: begin
        if (i_m1_req && i_m1_lock) begin
          w_g1 = 1'b1;
        end else begin
          w_g0 = w_rr_g0;
          w_g1 = w_rr_g1;
        end
      end
      default: begin
        w_g0 = w_rr_g0;
        w_g1 = w_rr_g1;
      end
    endcase
    if (!i_rst_n) begin
      w_g0 = 1'b0;
      w_g1 = 1'b0;
    end
  end

  // Next state, burst count and last winner. The count only advances for
  // locked M1 beats that make M0 wait; hitting the limit schedules a guard
  // beat for M0, after which a still-held lock hands the port back to M1.
  always_comb begin
    w_state_nxt = ARB_IDLE;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    if (w_g0 || !i_m1_lock) begin
      w_cnt_nxt = '0;
    end else if (w_g1 && i_m0_req && (r_cnt < CNT_MAX)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
    if (w_g0) begin
      w_last_nxt  = MST_M0;
      w_state_nxt = ((r_state == ARB_GUARD) && i_m1_lock) ? ARB_OWN1 : ARB_OWN0;
    end else if (w_g1) begin
      w_last_nxt = MST_M1;
      if (!i_m1_lock) begin
        w_state_nxt = ARB_IDLE;
      end else if (w_cnt_nxt >= CNT_MAX) begin
        w_state_nxt = ARB_GUARD;
      end else begin
        w_state_nxt = ARB_OWN1;
      end
    end
  end

  // Arbiter state registers; M1 counts as last winner so M0 wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ARB_IDLE;
      r_last  <= MST_M1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_m0_gnt = w_g0;
  assign o_m1_gnt = w_g1;

  // RAM request mux: the granted master's fields, zero when nobody is granted.
  always_comb begin
    w_wr        = 1'b0;
    o_ram_addr  = '0;
    o_ram_type  = '0;
    o_ram_wdata = '0;
    if (w_g0) begin
      w_wr        = i_m0_wr;
      o_ram_addr  = i_m0_addr;
      o_ram_type  = i_m0_type;
      o_ram_wdata = i_m0_wdata;
    end else if (w_g1) begin
      w_wr        = i_m1_wr;
      o_ram_addr  = i_m1_addr;
      o_ram_type  = i_m1_type;
      o_ram_wdata = i_m1_wdata;
    end
  end

  assign o_ram_rd_en = (w_g0 | w_g1) & ~w_wr;
  assign o_ram_wr_en = (w_g0 | w_g1) & w_wr;

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_vld   (o_ram_rd_en),
    .i_id    (w_g1),
    .o_vld   (w_tag_vld),
    .o_id    (w_tag_id)
  );

  // Returned data goes straight through in its valid cycle, then is held.
  assign o_m0_rvalid = w_tag_vld & (w_tag_id == MST_M0);
  assign o_m1_rvalid = w_tag_vld & (w_tag_id == MST_M1);
  assign o_m0_rdata  = o_m0_rvalid ? i_ram_rdata : r_m0_rdata;
  assign o_m1_rdata  = o_m1_rvalid ? i_ram_rdata : r_m1_rdata;

  // Hold registers for the last load data delivered to each master.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      r_m0_rdata <= o_m0_rdata;
      r_m1_rdata <= o_m1_rdata;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two instances (read latency 1 and 3) share one
// stimulus stream. A behavioural model predicts grants and read returns each
// cycle; directed sequences pin the model with literal grant patterns.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
  import riscv_mem_pkg::*;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_wr, m1_req, m1_wr, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, ram_rdata;
  logic [2:0]  m0_type, m1_type;

  logic [1:0]       m0_gnt, m0_rv, m1_gnt, m1_rv, rd_en, wr_en;
  logic [1:0][31:0] m0_rd, m1_rd, r_addr, r_wd;
  logic [1:0][2:0]  r_type;

  int nchk = 0;
  int nerr = 0;

  // model state
  int          cyc = 0;
  int          m_last = 1;
  int          m_burst = 0;
  bit          m_locked = 1'b0;
  int          sched [2][16];
  logic [31:0] hold [2][2];
  int          mtr[$];
  int          dtr[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ram_port_arbiter #(
      .AW(32), .DW(32), .RD_LAT(gi == 0 ? 1 : 3), .MAX_BURST(MAXB)
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_m0_req(m0_req), .i_m0_wr(m0_wr), .i_m0_addr(m0_addr), .i_m0_type(m0_type),
      .i_m0_wdata(m0_wdata), .o_m0_gnt(m0_gnt[gi]), .o_m0_rvalid(m0_rv[gi]),
      .o_m0_rdata(m0_rd[gi]),
      .i_m1_req(m1_req), .i_m1_wr(m1_wr), .i_m1_addr(m1_addr), .i_m1_type(m1_type),
      .i_m1_wdata(m1_wdata), .i_m1_lock(m1_lock), .o_m1_gnt(m1_gnt[gi]),
      .o_m1_rvalid(m1_rv[gi]), .o_m1_rdata(m1_rd[gi]),
      .o_ram_rd_en(rd_en[gi]), .o_ram_wr_en(wr_en[gi]), .o_ram_addr(r_addr[gi]),
      .o_ram_type(r_type[gi]), .o_ram_wdata(r_wd[gi]), .i_ram_rdata(ram_rdata)
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Who must be granted now, from the arbitration rules.
  function automatic int model_grant();
    if (m_burst >= MAXB && m0_req) return 0;
    if (m_locked && m1_req && m1_lock) return 1;
    if (m0_req && m1_req) return (m_last == 1) ? 0 : 1;
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  // Single compare process: every cycle, both instances against the model.
  always @(negedge clk) begin
    int          eg;
    int          em;
    logic        ewr;
    logic [31:0] ea, ed;
    logic [2:0]  et;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("rst_ctl", {26'd0, m0_gnt[i], m0_rv[i], m1_gnt[i], m1_rv[i], rd_en[i], wr_en[i]}, 32'd0);
        chk("rst_data", m0_rd[i] | m1_rd[i] | r_addr[i] | r_wd[i] | {29'd0, r_type[i]}, 32'd0);
        for (int s = 0; s < 16; s++) sched[i][s] = 0;
        hold[i][0] = '0;
        hold[i][1] = '0;
      end
      m_last = 1; m_burst = 0; m_locked = 1'b0;
    end else begin
      eg  = model_grant();
      ewr = (eg == 1) ? m1_wr : m0_wr;
      ea  = (eg == 1) ? m1_addr : m0_addr;
      ed  = (eg == 1) ? m1_wdata : m0_wdata;
      et  = (eg == 1) ? m1_type : m0_type;
      for (int i = 0; i < 2; i++) begin
        chk("gnt", {30'd0, m0_gnt[i], m1_gnt[i]}, {30'd0, eg == 0, eg == 1});
        chk("ram_en", {30'd0, rd_en[i], wr_en[i]}, {30'd0, (eg >= 0) && !ewr, (eg >= 0) && ewr});
        if (eg >= 0) begin
          chk("ram_addr", r_addr[i], ea);
          chk("ram_wdata_type", r_wd[i] ^ {29'd0, r_type[i]}, ed ^ {29'd0, et});
        end
        em = sched[i][cyc % 16];
        sched[i][cyc % 16] = 0;
        chk("rvalid", {30'd0, m0_rv[i], m1_rv[i]}, {30'd0, em == 1, em == 2});
        if (em == 1) hold[i][0] = ram_rdata;
        if (em == 2) hold[i][1] = ram_rdata;
        chk("m0_rdata", m0_rd[i], hold[i][0]);
        chk("m1_rdata", m1_rd[i], hold[i][1]);
        if (eg >= 0 && !ewr) sched[i][(cyc + lat_of(i)) % 16] = eg + 1;
      end
      mtr.push_back(eg);
      dtr.push_back(m0_gnt[0] ? 0 : (m1_gnt[0] ? 1 : -1));
      if (eg == 0) begin
        m_locked = (m_burst >= MAXB) && m1_lock;
        m_burst  = 0;
        m_last   = 0;
      end else if (eg == 1) begin
        m_locked = m1_lock;
        if (m0_req) m_burst++;
        m_last = 1;
      end else begin
        m_locked = 1'b0;
      end
      if (!m1_lock) m_burst = 0;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    ram_rdata = $urandom;
  endtask

  task automatic do_reset();
    step();
    m0_req = 0; m1_req = 0; m1_lock = 0; rst_n = 0;
    step();
    rst_n = 1;
  endtask

  // Compare recorded grants (model and instance 0) with a literal pattern.
  task automatic chk_trace(input string nm, input int st, input string pat);
    int e;
    for (int k = 0; k < pat.len(); k++) begin
      e = (pat.getc(k) == 8'd49) ? 1 : ((pat.getc(k) == 8'd48) ? 0 : -1);
      if (st + k >= mtr.size()) begin
        chk({nm, "_len"}, 32'(mtr.size()), 32'(st + k + 1));
      end else begin
        chk({nm, "_model"}, 32'(mtr[st + k]), 32'(e));
        chk({nm, "_dut"}, 32'(dtr[st + k]), 32'(e));
      end
    end
  endtask

  function automatic logic [2:0] pick_type();
    case ($urandom_range(0, 4))
      0:       return RW_B;
      1:       return RW_H;
      2:       return RW_W;
      3:       return RW_BU;
      default: return RW_HU;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, n, seen;
    bit g0, g1;
    rst_n = 0; m0_req = 0; m0_wr = 0; m0_addr = 0; m0_type = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_type = 0; m1_wdata = 0; m1_lock = 0;
    ram_rdata = 0;
    step();
    step();
    rst_n = 1;

    // single M0 load at 0x40
    step();
    m0_req = 1; m0_wr = 0; m0_addr = 32'h40; m0_type = RW_W;
    @(negedge clk);
    chk("t1_gnt", {30'd0, m0_gnt[0], m1_gnt[0]}, 32'd2);
    chk("t1_rd_en", {31'd0, rd_en[0]}, 32'd1);
    chk("t1_addr", r_addr[0], 32'h40);
    step();
    m0_req = 0; ram_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_rvalid", {30'd0, m0_rv[0], m1_rv[0]}, 32'd2);
    chk("t1_rdata", m0_rd[0], 32'hDEADBEEF);
    chk("t1_m1_rdata", m1_rd[0], 32'd0);

    // tie from reset: M0 first, then alternate
    do_reset();
    step();
    m0_req = 1; m1_req = 1; m0_wr = 0; m1_wr = 0; m1_addr = 32'h100;
    st = mtr.size();
    repeat (3) step();
    step();
    m0_req = 0; m1_req = 0;
    chk_trace("t2_rr", st, "0101");

    // locked M1 burst with M0 idle: never broken
    step();
    m1_req = 1; m1_lock = 1; m1_wr = 1; m1_addr = 32'h200;
    st = mtr.size();
    repeat (19) begin
      step();
      m1_addr += 4; m1_wdata = $urandom;
    end
    step();
    m1_req = 0; m1_lock = 0;
    chk_trace("t4_burst", st, "11111111111111111111");

    // locked M1 burst of 20 stores with M0 waiting: guard every 8 beats
    step();
    m0_req = 1; m0_wr = 1; m0_addr = 32'h80; m0_wdata = 32'h1111;
    st = mtr.size();
    step();
    m1_req = 1; m1_lock = 1; m1_wr = 1; m1_addr = 32'h300;
    n = 0;
    for (int k = 0; k < 60 && n < 20; k++) begin
      @(negedge clk);
      if (m1_gnt[0]) n++;
      step();
      if (m1_gnt[0] === 1'bx) n = 20;
      m1_addr += 4;
      if (n == 20) begin m1_req = 0; m1_lock = 0; end
    end
    chk("t3_m1_beats", 32'(n), 32'd20);
    step();
    m0_req = 0;
    chk_trace("t3_guard", st, "01111111101111111101111");

    // RD_LAT=3 instance: interleaved loads every cycle
    step();
    m0_req = 1; m0_wr = 0; m1_req = 1; m1_wr = 0; m1_lock = 0;
    st = mtr.size();
    repeat (3) step();
    ram_rdata = 32'hCAFE0003;
    @(negedge clk);
    chk("t5_lat3_m1_rv", {30'd0, m0_rv[1], m1_rv[1]}, 32'd1);
    chk("t5_lat3_m1_rd", m1_rd[1], 32'hCAFE0003);
    chk("t5_lat1_m1_rv", {31'd0, m1_rv[0]}, 32'd1);
    step();
    @(negedge clk);
    chk("t5_lat3_m0_rv", {30'd0, m0_rv[1], m1_rv[1]}, 32'd2);
    step();
    step();
    m0_req = 0; m1_req = 0;
    chk_trace("t5_rr", st, "101010");

    // reset with reads in flight: nothing may come back afterwards
    step();
    m0_req = 1; m1_req = 1; m0_wr = 0; m1_wr = 0;
    step();
    do_reset();
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(m0_rv[0]) + int'(m1_rv[0]) + int'(m0_rv[1]) + int'(m1_rv[1]);
      step();
    end
    chk("t6_no_rvalid", 32'(seen), 32'd0);
    chk("t6_rdata_clr", m0_rd[1] | m1_rd[1], 32'd0);

    // randomized protocol-respecting traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g0 = m0_gnt[0];
      g1 = m1_gnt[0];
      step();
      if (!m0_req || g0) begin
        m0_req = ($urandom_range(0, 99) < 55);
        m0_wr = $urandom_range(0, 1);
        m0_addr = $urandom;
        m0_type = pick_type();
        m0_wdata = $urandom;
      end
      if (!m1_req || g1) begin
        m1_req = ($urandom_range(0, 99) < 75);
        m1_wr = $urandom_range(0, 1);
        m1_addr = $urandom;
        m1_type = pick_type();
        m1_wdata = $urandom;
      end
      if ($urandom_range(0, 19) == 0) m1_lock = ~m1_lock;
    end
    step();
    m0_req = 0; m1_req = 0; m1_lock = 0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
